// File: rtl/sprdma.sv
// Sprite (OAM) DMA engine.
// Snoops CPU writes to 0x4014 and latches the written byte as the source page,
// then owns the bus to copy {page,8'h00}..{page,8'hFF} into PPU OAMDATA (0x2004).
// Each byte costs RD_LAT+1 read cycles plus one write cycle.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   cpu_a_in      snooped CPU address bus
//   cpu_d_in      snooped CPU write data
//   cpu_r_nw_in   snooped CPU R/!W
//   brk_in        debugger break; freezes the engine and its bus outputs
//   mem_d_in      read data returned from the memory controller
//   active_out    DMA owns the bus (CPU must be stalled)
//   done_out      one-cycle pulse after the final OAM write
//   mem_a_out     bus address while active
//   mem_d_out     bus write data while active
//   mem_r_nw_out  bus R/!W while active
module sprdma #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_a_in,
   input  logic [7:0]  cpu_d_in,
   input  logic        cpu_r_nw_in,
   input  logic        brk_in,
   input  logic [7:0]  mem_d_in,
   output logic        active_out,
   output logic        done_out,
   output logic [15:0] mem_a_out,
   output logic [7:0]  mem_d_out,
   output logic        mem_r_nw_out
);

   localparam int LW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT);
   localparam logic [LW-1:0] LAT_ONE  = LW'(1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t        state, state_d;
   logic [7:0]    page, page_d;
   logic [7:0]    idx, idx_d;
   logic [LW-1:0] lat_cnt, lat_d;
   logic          active_d, done_d, r_nw_d;
   logic [15:0]   a_d;
   logic [7:0]    dout_d;

   // All bus outputs are registered; the comb block computes their next values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         page         <= 8'h00;
         idx          <= 8'h00;
         lat_cnt      <= '0;
         active_out   <= 1'b0;
         done_out     <= 1'b0;
         mem_a_out    <= 16'h0000;
         mem_d_out    <= 8'h00;
         mem_r_nw_out <= 1'b1;
      end else begin
         state        <= state_d;
         page         <= page_d;
         idx          <= idx_d;
         lat_cnt      <= lat_d;
         active_out   <= active_d;
         done_out     <= done_d;
         mem_a_out    <= a_d;
         mem_d_out    <= dout_d;
         mem_r_nw_out <= r_nw_d;
      end
   end

   always_comb begin
      // Hold everything by default; brk_in simply skips every update.
      state_d  = state;
      page_d   = page;
      idx_d    = idx;
      lat_d    = lat_cnt;
      active_d = active_out;
      done_d   = done_out;
      a_d      = mem_a_out;
      dout_d   = mem_d_out;
      r_nw_d   = mem_r_nw_out;
      if (!brk_in) begin
         case (state)
            IDLE: begin
               done_d = 1'b0;
               // Full 16-bit compare so register mirrors never trigger.
               if (!cpu_r_nw_in && cpu_a_in == 16'h4014) begin
                  page_d   = cpu_d_in;
                  idx_d    = 8'h00;
                  lat_d    = '0;
                  state_d  = READ;
                  active_d = 1'b1;
                  a_d      = {cpu_d_in, 8'h00};
                  r_nw_d   = 1'b1;
                  dout_d   = 8'h00;
               end
            end
            READ: begin
               if (lat_cnt == LAT_LAST) begin
                  // Read data captured straight into the write-data register.
                  lat_d   = '0;
                  state_d = WRITE;
                  a_d     = 16'h2004;
                  r_nw_d  = 1'b0;
                  dout_d  = mem_d_in;
               end else begin
                  lat_d = lat_cnt + LAT_ONE;
               end
            end
            WRITE: begin
               r_nw_d = 1'b1;
               dout_d = 8'h00;
               if (idx == 8'hFF) begin
                  state_d  = DONE;
                  active_d = 1'b0;
                  done_d   = 1'b1;
                  a_d      = 16'h0000;
               end else begin
                  // Only the low byte advances; the page never increments.
                  idx_d   = idx + 8'd1;
                  state_d = READ;
                  a_d     = {page, idx + 8'd1};
               end
            end
            DONE: begin
               state_d  = IDLE;
               active_d = 1'b0;
               done_d   = 1'b0;
               a_d      = 16'h0000;
               dout_d   = 8'h00;
               r_nw_d   = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule
